// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle logic/arith/compare ops plus
// iterative shift-add multiply and restoring divide/remainder.
module seq_alu #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   output logic              i_ready,
   input  logic [WIDTH-1:0]  i_1,
   input  logic [WIDTH-1:0]  i_2,
   input  logic [CTRL_W-1:0] control,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [WIDTH-1:0]  result,
   output logic              zero_flag,
   output logic              busy
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(4'b0000);
   localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(4'b0001);
   localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(4'b0010);
   localparam logic [CTRL_W-1:0] OP_MUL  = CTRL_W'(4'b0011);
   localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(4'b0100);
   localparam logic [CTRL_W-1:0] OP_DIVU = CTRL_W'(4'b0101);
   localparam logic [CTRL_W-1:0] OP_REMU = CTRL_W'(4'b0110);
   localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(4'b1000);
   localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4'b1001);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [CTRL_W-1:0]   op_reg;
   logic [WIDTH-1:0]    a_reg;     // multiplicand (MUL) or divisor (DIV/REM)
   logic [WIDTH-1:0]    b_reg;     // multiplier (MUL) or dividend/quotient (DIV/REM)
   logic [WIDTH-1:0]    acc_reg;   // product (MUL) or partial remainder (DIV/REM)
   logic [WIDTH-1:0]    result_reg;
   logic                zero_reg;
   logic                valid_reg;

   logic                accept;
   logic                is_multi;
   logic [WIDTH-1:0]    single_res;
   logic [WIDTH-1:0]    mul_acc_next;
   logic [WIDTH:0]      rem_shift;
   logic [WIDTH:0]      rem_diff;
   logic [WIDTH-1:0]    div_rem_next;
   logic [WIDTH-1:0]    div_quo_next;
   logic [WIDTH-1:0]    multi_res;

   assign i_ready   = (state_reg == IDLE) || (state_reg == DONE && o_ready);
   assign accept    = i_valid && i_ready;
   assign is_multi  = (control == OP_MUL) || (control == OP_DIVU) || (control == OP_REMU);
   assign o_valid   = valid_reg;
   assign result    = result_reg;
   assign zero_flag = zero_reg;
   assign busy      = (state_reg == CALC);

   always_comb begin
      single_res = '0;
      case (control)
         OP_AND:  single_res = i_1 & i_2;
         OP_OR:   single_res = i_1 | i_2;
         OP_ADD:  single_res = i_1 + i_2;
         OP_SUB:  single_res = i_1 - i_2;
         OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (i_1 < i_2)};
         OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(i_1) < $signed(i_2))};
         default: single_res = '0;
      endcase
   end

   // One iteration of each algorithm; a zero divisor naturally yields
   // an all-ones quotient and a remainder equal to the dividend.
   always_comb begin
      mul_acc_next = acc_reg + (b_reg[0] ? a_reg : '0);
      rem_shift    = {acc_reg, b_reg[WIDTH-1]};
      rem_diff     = rem_shift - {1'b0, a_reg};
      if (!rem_diff[WIDTH]) begin
         div_rem_next = rem_diff[WIDTH-1:0];
         div_quo_next = {b_reg[WIDTH-2:0], 1'b1};
      end else begin
         div_rem_next = rem_shift[WIDTH-1:0];
         div_quo_next = {b_reg[WIDTH-2:0], 1'b0};
      end
      case (op_reg)
         OP_MUL:  multi_res = mul_acc_next;
         OP_DIVU: multi_res = div_quo_next;
         default: multi_res = div_rem_next;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         op_reg     <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         acc_reg    <= '0;
         result_reg <= '0;
         zero_reg   <= 1'b1;
         valid_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (accept) begin
                  if (is_multi) begin
                     state_reg <= CALC;
                     cnt_reg   <= '0;
                     op_reg    <= control;
                     acc_reg   <= '0;
                     valid_reg <= 1'b0;
                     if (control == OP_MUL) begin
                        a_reg <= i_1;
                        b_reg <= i_2;
                     end else begin
                        a_reg <= i_2;
                        b_reg <= i_1;
                     end
                  end else begin
                     state_reg  <= DONE;
                     result_reg <= single_res;
                     zero_reg   <= (single_res == '0);
                     valid_reg  <= 1'b1;
                  end
               end else if (state_reg == DONE && o_ready) begin
                  state_reg <= IDLE;
                  valid_reg <= 1'b0;
               end
            end
            CALC: begin
               cnt_reg <= cnt_reg + 1'b1;
               if (op_reg == OP_MUL) begin
                  acc_reg <= mul_acc_next;
                  a_reg   <= a_reg << 1;
                  b_reg   <= b_reg >> 1;
               end else begin
                  acc_reg <= div_rem_next;
                  b_reg   <= div_quo_next;
               end
               if (cnt_reg == CNT_W'(WIDTH-1)) begin
                  state_reg  <= DONE;
                  result_reg <= multi_res;
                  zero_reg   <= (multi_res == '0);
                  valid_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32) with hand-computed results.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        i_ready;
   logic [31:0] i_1;
   logic [31:0] i_2;
   logic [3:0]  control;
   logic        o_valid;
   logic        o_ready;
   logic [31:0] result;
   logic        zero_flag;
   logic        busy;

   int checks = 0;
   int errors = 0;

   localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                          C_MUL = 4'b0011, C_SUB = 4'b0100, C_DIVU = 4'b0101,
                          C_REMU = 4'b0110, C_SLTU = 4'b1000, C_SLT = 4'b1001;

   seq_alu #(.WIDTH(32), .CTRL_W(4)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
      .i_1(i_1), .i_2(i_2), .control(control), .o_valid(o_valid),
      .o_ready(o_ready), .result(result), .zero_flag(zero_flag), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op from IDLE, wait for o_valid, check latency, busy span and result.
   task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat, busy_n, rdy_bad;
      @(negedge clk);
      control = ctrl; i_1 = a; i_2 = b; i_valid = 1'b1; o_ready = 1'b1;
      chk({tag, "_iready"}, {31'd0, i_ready}, 32'd1);
      @(posedge clk); #1;
      i_valid = 1'b0; i_1 = ~a; i_2 = ~b; control = C_ADD;
      lat = 0; busy_n = 0; rdy_bad = 0;
      do begin
         @(negedge clk);
         lat++;
         if (busy) busy_n++;
         if (busy && i_ready) rdy_bad++;
      end while (!o_valid && lat < 100);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_res"}, result, exp);
      chk({tag, "_zero"}, {31'd0, zero_flag}, {31'd0, (exp == 32'd0)});
      if (exp_lat > 1) begin
         chk({tag, "_busy"}, busy_n, exp_lat - 1);
         chk({tag, "_rdy_calc"}, rdy_bad, 0);
      end
      $display("op %s ctrl=%b a=%h b=%h -> result=%h zero=%0d lat=%0d",
               tag, ctrl, a, b, result, zero_flag, lat);
   endtask

   initial begin
      rst = 1'b1; i_valid = 1'b0; i_1 = '0; i_2 = '0; control = '0; o_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", {31'd0, zero_flag}, 32'd1);
      chk("rst_ovalid", {31'd0, o_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      #1 chk("rst_iready", {31'd0, i_ready}, 32'd1);

      run_op("add_wrap", C_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
      run_op("slt",      C_SLT,  32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1);
      run_op("sltu",     C_SLTU, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1);
      run_op("and",      C_AND,  32'hF0F0_1234, 32'hFF00_FF0F, 32'hF000_1204, 1);
      run_op("sub_neg",  C_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1);
      run_op("bad_op",   4'b0111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1);
      run_op("mul",      C_MUL,  32'h0001_2345, 32'h0001_0000, 32'h2345_0000, 33);
      run_op("mul_max",  C_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
      run_op("divu",     C_DIVU, 32'd100, 32'd7, 32'd14, 33);
      run_op("remu",     C_REMU, 32'd100, 32'd7, 32'd2, 33);
      run_op("divu_z",   C_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 33);
      run_op("remu_z",   C_REMU, 32'd5, 32'd0, 32'd5, 33);
      run_op("divu_big", C_DIVU, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 33);
      run_op("remu_big", C_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, 33);

      // Backpressure: SUB 3-3 held for 5 cycles, then a back-to-back OR.
      @(negedge clk);
      control = C_SUB; i_1 = 32'd3; i_2 = 32'd3; i_valid = 1'b1; o_ready = 1'b0;
      @(posedge clk); #1 i_valid = 1'b0; i_1 = 32'd9;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_ovalid", {31'd0, o_valid}, 32'd1);
         chk("hold_result", result, 32'd0);
         chk("hold_zero", {31'd0, zero_flag}, 32'd1);
         chk("hold_iready", {31'd0, i_ready}, 32'd0);
      end
      $display("op hold_sub ctrl=%b a=3 b=3 -> result=%h held 5 cycles", C_SUB, result);
      @(negedge clk);
      o_ready = 1'b1; i_valid = 1'b1; control = C_OR; i_1 = 32'h0000_00F0; i_2 = 32'h0000_000F;
      #1 chk("b2b_iready", {31'd0, i_ready}, 32'd1);
      @(posedge clk); #1 i_valid = 1'b0;
      @(negedge clk);
      chk("b2b_result", result, 32'h0000_00FF);
      chk("b2b_ovalid", {31'd0, o_valid}, 32'd1);
      chk("b2b_zero", {31'd0, zero_flag}, 32'd0);
      $display("op b2b_or ctrl=%b a=000000f0 b=0000000f -> result=%h", C_OR, result);
      @(negedge clk);
      chk("b2b_drop", {31'd0, o_valid}, 32'd0);

      // Asynchronous reset in the middle of a divide.
      @(negedge clk);
      control = C_DIVU; i_1 = 32'd100; i_2 = 32'd7; i_valid = 1'b1;
      @(posedge clk); #1 i_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_ovalid", {31'd0, o_valid}, 32'd0);
      chk("arst_result", result, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_zero", {31'd0, zero_flag}, 32'd1);
      $display("op arst_divu interrupted -> result=%h busy=%0d", result, busy);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("arst_iready", {31'd0, i_ready}, 32'd1);
      run_op("add_post", C_ADD, 32'd2, 32'd2, 32'd4, 1);
      begin
         int stale = 0;
         o_ready = 1'b1;
         repeat (40) begin
            @(negedge clk);
            if (o_valid || busy) stale++;
         end
         chk("no_stale", stale, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
